// File: rtl/subtractor_seq.sv
// Multi-cycle subtractor: diff = a + ~b + 1, one CHUNK_W slice per cycle, LSB first.
// Define SUB_OVERFLOW_EN to register signed overflow; otherwise overflow_o is tied low.
module subtractor_seq #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] diff_o,
  output logic              borrow_o,
  output logic              overflow_o
);

  localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  if (DATA_W % CHUNK_W != 0) begin : g_bad_chunk
    $error("subtractor_seq: DATA_W must be a multiple of CHUNK_W");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [DATA_W-1:0]  a_q, b_q, diff_q;
  logic               borrow_q;
  logic [CHUNK_W-1:0] a_sl, b_sl;
  logic [CHUNK_W:0]   sum;
  logic               last;

  function automatic logic [CHUNK_W:0] slice_sub(input logic [CHUNK_W-1:0] x,
                                                 input logic [CHUNK_W-1:0] y,
                                                 input logic              cin);
    return {1'b0, x} + {1'b0, ~y} + {{CHUNK_W{1'b0}}, cin};
  endfunction

  assign a_sl = a_q[idx*CHUNK_W +: CHUNK_W];
  assign b_sl = b_q[idx*CHUNK_W +: CHUNK_W];
  assign sum  = slice_sub(a_sl, b_sl, carry);
  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = BUSY;
      BUSY:    if (last)    state_nxt = DONE;
      DONE:    if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);

  // Operand capture and per-slice ripple; carry flop links consecutive slices.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx      <= '0;
      carry    <= 1'b1;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            idx    <= '0;
            carry  <= 1'b1;
            diff_q <= '0;
          end
        end
        BUSY: begin
          diff_q[idx*CHUNK_W +: CHUNK_W] <= sum[CHUNK_W-1:0];
          carry <= sum[CHUNK_W];
          idx   <= last ? '0 : idx + 1'b1;
          if (last) borrow_q <= ~sum[CHUNK_W];
        end
        default: ;
      endcase
    end
  end

  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;

`ifdef SUB_OVERFLOW_EN
  logic ovf_q;

  // The final slice's sum MSB is the result sign bit, available before diff_q updates.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      ovf_q <= 1'b0;
    else if (state == BUSY && last)
      ovf_q <= (a_q[DATA_W-1] != b_q[DATA_W-1]) && (sum[CHUNK_W-1] != a_q[DATA_W-1]);
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_subtractor_seq.sv
// Randomized self-checking bench for subtractor_seq against an arithmetic reference model.
module tb_subtractor_seq;

  localparam int DATA_W     = 32;
  localparam int NUM_CHUNKS = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] a_i, b_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] diff_o;
  logic              borrow_o;
  logic              overflow_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int last_acc = -100;

  subtractor_seq dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .diff_o     (diff_o),
    .borrow_o   (borrow_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: plain modular and signed arithmetic on the operands.
  function automatic logic [DATA_W-1:0] ref_diff(input logic [DATA_W-1:0] a, b);
    return a - b;
  endfunction

  function automatic logic ref_borrow(input logic [DATA_W-1:0] a, b);
    return a < b;
  endfunction

  function automatic logic ref_ovf(input logic [DATA_W-1:0] a, b);
`ifdef SUB_OVERFLOW_EN
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    return (d > 64'sd2147483647) || (d < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  // Issue one operation, optionally stall the result for `stall` cycles, then consume it.
  task automatic run_op(input logic [DATA_W-1:0] a, b, input int stall);
    int w;
    int lat;
    logic [DATA_W-1:0] ed;
    logic eb, eo;
    ed = ref_diff(a, b);
    eb = ref_borrow(a, b);
    eo = ref_ovf(a, b);
    w = 0;
    while (!ready_o && w < 50) begin tick(); w++; end
    if (!ready_o) check("ready_timeout", 0, 1);
    valid_i = 1'b1;
    a_i     = a;
    b_i     = b;
    ready_i = (stall == 0);
    tick();
    if (cyc - last_acc < NUM_CHUNKS + 2) check("issue_interval", cyc - last_acc, NUM_CHUNKS + 2);
    last_acc = cyc;
    lat = 0;
    while (!valid_o && lat < 20) begin
      valid_i = 1'($urandom);
      a_i     = $urandom;
      b_i     = $urandom;
      tick();
      lat++;
    end
    check("latency", lat, NUM_CHUNKS);
    check("diff", diff_o, ed);
    check("borrow", borrow_o, eb);
    check("overflow", overflow_o, eo);
    for (int i = 0; i < stall; i++) begin
      valid_i = 1'($urandom);
      a_i     = $urandom;
      b_i     = $urandom;
      tick();
      check("stall_valid", valid_o, 1);
      check("stall_ready", ready_o, 0);
      check("stall_diff", diff_o, ed);
      check("stall_borrow", borrow_o, eb);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    check("consume_valid", valid_o, 0);
    check("consume_ready", ready_o, 1);
  endtask

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    a_i     = '0;
    b_i     = '0;
    tick();
    tick();
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_diff", diff_o, 0);
    check("rst_borrow", borrow_o, 0);
    check("rst_ovf", overflow_o, 0);
    rst_ni = 1'b1;
    tick();

    run_op(32'd5, 32'd3, 0);
    run_op(32'd3, 32'd5, 0);
    run_op(32'h0000_0100, 32'h0000_0001, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 0);
    run_op(32'hDEAD_BEEF, 32'h0, 0);
    run_op(32'h0, 32'h1, 0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 10);

    // Abort in the second BUSY cycle.
    valid_i = 1'b1;
    a_i     = 32'hFFFF_FFFF;
    b_i     = 32'h1234_5678;
    tick();
    valid_i = 1'b0;
    tick();
    rst_ni = 1'b0;
    tick();
    check("abort_valid", valid_o, 0);
    check("abort_ready", ready_o, 1);
    check("abort_diff", diff_o, 0);
    check("abort_borrow", borrow_o, 0);
    check("abort_ovf", overflow_o, 0);
    rst_ni = 1'b1;
    last_acc = -100;
    for (int i = 0; i < NUM_CHUNKS + 2; i++) begin
      tick();
      check("abort_no_result", valid_o, 0);
    end
    run_op(32'd10, 32'd10, 0);

    for (int i = 0; i < 1000; i++) begin
      logic [DATA_W-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      run_op(ra, rb, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/subtractor_seq.md
Name: subtractor_seq

Overview:
- Multi-cycle unsigned/two's-complement subtractor for the calculator datapath; the inverse operation of the combinational 32-bit adder.
- Computes diff_o = a_i - b_i as a + ~b + 1, one CHUNK_W-bit slice per cycle, LSB slice first.
- The borrow/carry is held in a flop between slices.
- Valid/ready handshake on both the operand side and the result side, so it sits between the operand register stage and the result writeback stage.

Parameters:
- DATA_W, calculator_pkg::DATA_W (32), operand and result width.
- CHUNK_W, 8, bits processed per cycle. DATA_W % CHUNK_W must be 0, otherwise elaboration fails via $error.
- NUM_CHUNKS, DATA_W/CHUNK_W (4), derived localparam, not overridable.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  synchronous active-low reset
- valid_i  input  1  operand pair valid
- ready_o  output  1  block can accept operands
- a_i  input  DATA_W  minuend
- b_i  input  DATA_W  subtrahend
- valid_o  output  1  result valid
- ready_i  input  1  downstream accepts result
- diff_o  output  DATA_W  a_i - b_i modulo 2^DATA_W
- borrow_o  output  1  1 when a_i < b_i (unsigned)
- overflow_o  output  1  signed overflow; see Optional Feature

Behaviour:
- Clocking and reset:
  - One clock, clk_i. Reset is synchronous and active-low on rst_ni. All state changes occur on the rising edge of clk_i.
  - Reset values: state=IDLE, ready_o=1, valid_o=0, diff_o=0, borrow_o=0, overflow_o=0, chunk index=0, carry flop=1.
- State machine:
  - IDLE:
    - ready_o=1.
    - On valid_i && ready_o: latch a_i and b_i, set chunk index=0, carry=1, clear the diff register, go to BUSY.
  - BUSY:
    - ready_o=0, valid_o=0.
    - Each cycle: slice k = a[k] + ~b[k] + carry. The CHUNK_W-bit sum is written into diff slice k, and the slice carry-out goes to the carry flop. Then k++.
    - After slice NUM_CHUNKS-1: borrow = ~final carry-out, go to DONE.
  - DONE:
    - valid_o=1. diff_o, borrow_o and overflow_o are stable.
    - On ready_i: go to IDLE, valid_o=0 next cycle.
    - If ready_i is low, hold all outputs indefinitely.
- Latency and throughput:
  - valid_o rises exactly NUM_CHUNKS cycles after the accepting edge (4 at default).
  - ready_o is high only in IDLE, so no new operand is accepted in the same cycle a result is consumed.
  - Minimum issue interval is NUM_CHUNKS+2 cycles.
- Input stability: a_i and b_i are sampled only at the accepting edge. Changes during BUSY or DONE have no effect.
- Outputs: diff_o, borrow_o and overflow_o are driven from registers and are undefined-free at all times. They may hold partial or old values outside DONE, but are only meaningful while valid_o=1.
- Boundary conditions:
  - a==b: diff=0, borrow=0.
  - b=0: diff=a, borrow=0.
  - a=0, b=1: diff=all-ones, borrow=1.
  - CHUNK_W=DATA_W: a single BUSY cycle, latency 1.
  - valid_i asserted while not ready: ignored, and must not corrupt the in-flight operation.
- Reset mid-operation: rst_ni low in BUSY or DONE aborts the operation, and every output returns to its reset value on that edge. No result is emitted for the aborted operation.

Optional Feature:
- Macro: SUB_OVERFLOW_EN.
- Defined:
  - overflow_o is registered at the BUSY->DONE transition as (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]).
  - It is valid with valid_o.
- Not defined:
  - overflow_o is tied to 0.
  - No sign-compare logic is synthesized.
  - All other behaviour is identical.

Test Plan:
- Basic subtraction, ready_i=1: reset, then a=5, b=3 -> valid_o exactly 4 cycles after the accept edge, with diff=0x00000002, borrow=0, overflow=0.
- Borrow across slices: a=3, b=5 -> diff=0xFFFFFFFE, borrow=1. Also a=0x00000100, b=0x00000001 -> diff=0x000000FF, borrow=0, exercising the carry between slices.
- Signed overflow: a=0x80000000, b=1 -> diff=0x7FFFFFFF, borrow=0, overflow=1 with SUB_OVERFLOW_EN defined and 0 without it.
- Backpressure: hold ready_i=0 for 10 cycles in DONE while toggling valid_i, a_i and b_i -> outputs stable, ready_o=0, no new accept. Raise ready_i -> handshake completes, ready_o=1 the cycle after.
- Reset mid-op: accept a=0xFFFFFFFF, b=0x12345678, then drive rst_ni=0 in the second BUSY cycle -> next edge gives valid_o=0, ready_o=1, diff=0. A fresh a=10, b=10 afterwards -> diff=0, borrow=0.
- Back-to-back with random operands (1000 pairs, ready_i random): every result equals (a-b) mod 2^32 and borrow equals (a<b). Issue interval is never below 6 cycles.
